polyphase_coeff_loader: RTL and testbench

Controller that sequences run-time coefficient reloads of the interpolating polyphase filter. It takes a coefficient stream, waits for the in-flight data frame to finish and drain through the filter, then writes NUMBER_TAPS coefficients through the filter's coeffs_wren/addr/wdata port. It also gates the filter's input data stream so no sample is filtered with a partially written table. It sits between the upstream sample source and polyphase_filter, in the filter's input clock domain.

---
 rtl/polyphase_coeff_loader_pkg.sv | 15 +
 rtl/polyphase_frame_tracker.sv | 54 +++++
 rtl/polyphase_coeff_loader.sv | 171 +++++++++++++++++
 tb/tb_polyphase_coeff_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyphase_coeff_loader_pkg.sv
// Shared types and constants for the polyphase coefficient loader
// and its frame tracker.
package polyphase_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      LOAD,
      FLUSH
   } state_t;

   localparam int NUMBER_TAPS_DEF = 32;
   localparam int COEF_ADDR_W     = $clog2(NUMBER_TAPS_DEF);

endpackage

// File: rtl/polyphase_frame_tracker.sv
// Tracks whether a data frame is open upstream of the filter and how
// many completed frames are still draining through it.
module polyphase_frame_tracker
   import polyphase_pkg::*;
#(
   parameter int INFLIGHT_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      data_hs,
   input  logic                      data_last,
   input  logic                      filt_out_tlast_hs,
   output logic                      in_frame,
   output logic [INFLIGHT_WIDTH-1:0] inflight
);

   localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_MAX = '1;

   logic                      in_frame_d;
   logic                      in_frame_q;
   logic [INFLIGHT_WIDTH-1:0] inflight_d;
   logic [INFLIGHT_WIDTH-1:0] inflight_q;
   logic                      frame_end;

   assign frame_end = data_hs && data_last;

   always_comb begin
      in_frame_d = in_frame_q;
      inflight_d = inflight_q;
      if (data_hs) begin
         in_frame_d = !data_last;
      end
      // Simultaneous enter and drain cancel; both ends saturate.
      if (frame_end && !filt_out_tlast_hs && (inflight_q != INFLIGHT_MAX)) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!frame_end && filt_out_tlast_hs && (inflight_q != '0)) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_frame_q <= 1'b0;
         inflight_q <= '0;
      end else begin
         in_frame_q <= in_frame_d;
         inflight_q <= inflight_d;
      end
   end

   assign in_frame = in_frame_q;
   assign inflight = inflight_q;

endmodule

// File: rtl/polyphase_coeff_loader.sv
// Sequences run-time coefficient reloads of the polyphase filter and
// gates its input stream while the table is being rewritten.
module polyphase_coeff_loader
   import polyphase_pkg::*;
#(
   parameter int NUMBER_TAPS       = NUMBER_TAPS_DEF,
   parameter int COEFFICIENT_WIDTH = 16,
   parameter int DATA_IN_WIDTH     = 16,
   parameter int INFLIGHT_WIDTH    = 4,
   parameter int REQUIRE_VALID     = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [COEFFICIENT_WIDTH-1:0] s_coef_tdata,
   input  logic                         s_coef_tvalid,
   input  logic                         s_coef_tlast,
   output logic                         s_coef_tready,
   input  logic [DATA_IN_WIDTH-1:0]     s_data_tdata,
   input  logic                         s_data_tvalid,
   input  logic                         s_data_tlast,
   output logic                         s_data_tready,
   output logic [DATA_IN_WIDTH-1:0]     m_data_tdata,
   output logic                         m_data_tvalid,
   output logic                         m_data_tlast,
   input  logic                         m_data_tready,
   input  logic                         filt_out_tlast_hs,
   output logic                         coeffs_wren,
   output logic [COEF_ADDR_W-1:0]       coeffs_addr,
   output logic [COEFFICIENT_WIDTH-1:0] coeffs_wdata,
   output logic                         busy,
   output logic                         coef_valid,
   output logic                         load_done,
   output logic                         load_error,
   output logic                         err_long
);

   localparam logic [COEF_ADDR_W-1:0] LAST_ADDR = COEF_ADDR_W'(NUMBER_TAPS - 1);

   state_t                       state_d, state_q;
   logic [COEF_ADDR_W-1:0]       count_d, count_q;
   logic                         coef_valid_d, coef_valid_q;
   logic                         wren_d, wren_q;
   logic [COEF_ADDR_W-1:0]       addr_d, addr_q;
   logic [COEFFICIENT_WIDTH-1:0] wdata_d, wdata_q;
   logic                         done_d, done_q;
   logic                         error_d, error_q;
   logic                         err_long_d, err_long_q;

   logic                      in_frame;
   logic [INFLIGHT_WIDTH-1:0] inflight;
   logic                      gate_open;
   logic                      data_hs;
   logic                      coef_hs;

   // Mid-frame requests let the open frame finish; nothing new starts.
   assign gate_open = ((state_q == IDLE) || ((state_q == WAIT) && in_frame))
                   && (coef_valid_q || (REQUIRE_VALID == 0) || in_frame);

   assign m_data_tdata  = s_data_tdata;
   assign m_data_tlast  = s_data_tlast;
   assign m_data_tvalid = s_data_tvalid && gate_open;
   assign s_data_tready = m_data_tready && gate_open;
   assign data_hs       = s_data_tvalid && s_data_tready;
   assign coef_hs       = s_coef_tvalid && s_coef_tready;

   polyphase_frame_tracker #(
      .INFLIGHT_WIDTH(INFLIGHT_WIDTH)
   ) u_tracker (
      .clock            (clock),
      .reset            (reset),
      .data_hs          (data_hs),
      .data_last        (s_data_tlast),
      .filt_out_tlast_hs(filt_out_tlast_hs),
      .in_frame         (in_frame),
      .inflight         (inflight)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      coef_valid_d  = coef_valid_q;
      wren_d        = 1'b0;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      done_d        = 1'b0;
      error_d       = 1'b0;
      err_long_d    = err_long_q;
      s_coef_tready = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_coef_tvalid) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!in_frame && (inflight == '0)) begin
               state_d      = LOAD;
               count_d      = '0;
               coef_valid_d = 1'b0;
            end
         end
         LOAD: begin
            s_coef_tready = 1'b1;
            if (coef_hs) begin
               wren_d  = 1'b1;
               addr_d  = count_q;
               wdata_d = s_coef_tdata;
               count_d = count_q + 1'b1;
               if (count_q == LAST_ADDR) begin
                  if (s_coef_tlast) begin
                     state_d      = IDLE;
                     coef_valid_d = 1'b1;
                     done_d       = 1'b1;
                  end else begin
                     state_d    = FLUSH;
                     error_d    = 1'b1;
                     err_long_d = 1'b1;
                  end
               end else if (s_coef_tlast) begin
                  state_d    = IDLE;
                  error_d    = 1'b1;
                  err_long_d = 1'b0;
               end
            end
         end
         FLUSH: begin
            s_coef_tready = 1'b1;
            if (coef_hs && s_coef_tlast) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         coef_valid_q <= 1'b0;
         wren_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_long_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         coef_valid_q <= coef_valid_d;
         wren_q       <= wren_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_long_q   <= err_long_d;
      end
   end

   assign coeffs_wren  = wren_q;
   assign coeffs_addr  = addr_q;
   assign coeffs_wdata = wdata_q;
   assign busy         = (state_q != IDLE);
   assign coef_valid   = coef_valid_q;
   assign load_done    = done_q;
   assign load_error   = error_q;
   assign err_long     = err_long_q;

endmodule

// File: tb/tb_polyphase_coeff_loader.sv
// Directed bench for polyphase_coeff_loader: gate vectors plus
// full, short, long, mid-frame, drain and reset-during-load sequences.
module tb_polyphase_coeff_loader;
   import polyphase_pkg::*;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic [15:0]            s_coef_tdata = '0;
   logic                   s_coef_tvalid = 1'b0;
   logic                   s_coef_tlast = 1'b0;
   logic                   s_coef_tready;
   logic [15:0]            s_data_tdata = '0;
   logic                   s_data_tvalid = 1'b0;
   logic                   s_data_tlast = 1'b0;
   logic                   s_data_tready;
   logic [15:0]            m_data_tdata;
   logic                   m_data_tvalid;
   logic                   m_data_tlast;
   logic                   m_data_tready = 1'b0;
   logic                   filt_out_tlast_hs = 1'b0;
   logic                   coeffs_wren;
   logic [COEF_ADDR_W-1:0] coeffs_addr;
   logic [15:0]            coeffs_wdata;
   logic                   busy;
   logic                   coef_valid;
   logic                   load_done;
   logic                   load_error;
   logic                   err_long;

   polyphase_coeff_loader dut (
      .clock            (clock),
      .reset            (reset),
      .s_coef_tdata     (s_coef_tdata),
      .s_coef_tvalid    (s_coef_tvalid),
      .s_coef_tlast     (s_coef_tlast),
      .s_coef_tready    (s_coef_tready),
      .s_data_tdata     (s_data_tdata),
      .s_data_tvalid    (s_data_tvalid),
      .s_data_tlast     (s_data_tlast),
      .s_data_tready    (s_data_tready),
      .m_data_tdata     (m_data_tdata),
      .m_data_tvalid    (m_data_tvalid),
      .m_data_tlast     (m_data_tlast),
      .m_data_tready    (m_data_tready),
      .filt_out_tlast_hs(filt_out_tlast_hs),
      .coeffs_wren      (coeffs_wren),
      .coeffs_addr      (coeffs_addr),
      .coeffs_wdata     (coeffs_wdata),
      .busy             (busy),
      .coef_valid       (coef_valid),
      .load_done        (load_done),
      .load_error       (load_error),
      .err_long         (err_long)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int wr_n = 0;
   int done_n = 0;
   int err_n = 0;
   int acc_n = 0;
   logic [15:0] wr_addr [512];
   logic [15:0] wr_data [512];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (coeffs_wren && wr_n < 512) begin
         wr_addr[wr_n] = 16'(coeffs_addr);
         wr_data[wr_n] = coeffs_wdata;
         wr_n++;
      end
      if (load_done) begin
         done_n++;
         chk("done_with_final_wren", {coeffs_wren, coef_valid, 16'(coeffs_addr)},
             {1'b1, 1'b1, 16'd31});
      end
      if (load_error) err_n++;
   end

   task automatic settle();
      repeat (2) @(negedge clock);
      #1;
   endtask

   task automatic send_coef(int n, bit last, int off);
      for (int i = 0; i < n; i++) begin
         int g = 0;
         s_coef_tvalid = 1'b1;
         s_coef_tdata  = 16'(i + off);
         s_coef_tlast  = last && (i == n - 1);
         while (!s_coef_tready && g < 200) begin
            @(negedge clock);
            g++;
         end
         chk("coef_ready", 32'(s_coef_tready), 1);
         if (!s_coef_tready) break;
         @(negedge clock);
      end
      s_coef_tvalid = 1'b0;
      s_coef_tlast  = 1'b0;
   endtask

   task automatic send_sample(logic [15:0] d, bit last);
      int g = 0;
      s_data_tvalid = 1'b1;
      s_data_tdata  = d;
      s_data_tlast  = last;
      while (!s_data_tready && g < 50) begin
         @(negedge clock);
         g++;
      end
      chk("sample_ready", 32'(s_data_tready), 1);
      if (s_data_tready) begin
         @(negedge clock);
         acc_n++;
      end
      s_data_tvalid = 1'b0;
      s_data_tlast  = 1'b0;
   endtask

   task automatic check_writes(string nm, int base, int n, int off);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         if (wr_addr[base+k] !== 16'(k) || wr_data[base+k] !== 16'(k + off)) bad++;
      end
      chk(nm, bad, 0);
   endtask

   typedef struct {
      logic        v;
      logic        last;
      logic        rdy;
      logic [15:0] d;
      logic        ev;
      logic        er;
   } vec_t;

   vec_t vt [8];

   task automatic apply_vec(int i);
      @(negedge clock);
      s_data_tvalid = vt[i].v;
      s_data_tlast  = vt[i].last;
      s_data_tdata  = vt[i].d;
      m_data_tready = vt[i].rdy;
      #1;
      chk("vec_m_tvalid", 32'(m_data_tvalid), 32'(vt[i].ev));
      chk("vec_s_tready", 32'(s_data_tready), 32'(vt[i].er));
      chk("vec_tdata", 32'(m_data_tdata), 32'(vt[i].d));
      chk("vec_tlast", 32'(m_data_tlast), 32'(vt[i].last));
      s_data_tvalid = 1'b0;
      s_data_tlast  = 1'b0;
      m_data_tready = 1'b0;
   endtask

   initial begin
      int base;
      int d0;
      int e0;
      int blocked;
      int cnt;

      vt[0] = '{1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0abc, 1'b0, 1'b0};
      vt[3] = '{1'b1, 1'b0, 1'b0, 16'h0def, 1'b0, 1'b0};
      vt[4] = '{1'b1, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1};
      vt[5] = '{1'b0, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b1};
      vt[6] = '{1'b1, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b0};
      vt[7] = '{1'b0, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0};

      // reset state
      repeat (3) @(negedge clock);
      #1;
      chk("rst_outputs",
          {coeffs_wren, busy, coef_valid, load_done, load_error, err_long,
           s_coef_tready, s_data_tready, m_data_tvalid},
          0);
      chk("rst_addr_data", {16'(coeffs_addr), coeffs_wdata}, 0);
      reset = 1'b0;

      // gate closed before any table
      for (int i = 0; i < 4; i++) apply_vec(i);

      // full 32-beat load
      base = wr_n;
      d0   = done_n;
      send_coef(32, 1'b1, 0);
      settle();
      chk("full_wr_count", wr_n - base, 32);
      check_writes("full_wr_seq", base, 32, 0);
      chk("full_done", done_n - d0, 1);
      chk("full_valid", 32'(coef_valid), 1);
      chk("full_idle", 32'(busy), 0);

      // gate open after a good table
      for (int i = 4; i < 8; i++) apply_vec(i);

      // request arrives mid-frame
      m_data_tready = 1'b1;
      acc_n = 0;
      for (int i = 0; i < 3; i++) send_sample(16'(i), 1'b0);
      base = wr_n;
      d0   = done_n;
      fork
         send_coef(32, 1'b1, 16'h0200);
         begin
            for (int i = 3; i < 8; i++) send_sample(16'(i), i == 7);
            s_data_tvalid = 1'b1;
            s_data_tdata  = 16'h0bad;
            blocked = 0;
            repeat (4) begin
               @(negedge clock);
               if (!s_data_tready && !m_data_tvalid) blocked++;
            end
            s_data_tvalid = 1'b0;
            chk("midframe_accepted", acc_n, 8);
            chk("new_frame_blocked", blocked, 4);
            chk("no_load_before_drain", wr_n - base, 0);
            chk("busy_in_wait", 32'(busy), 1);
            filt_out_tlast_hs = 1'b1;
            @(negedge clock);
            filt_out_tlast_hs = 1'b0;
         end
      join
      settle();
      chk("midframe_wr_count", wr_n - base, 32);
      check_writes("midframe_wr_seq", base, 32, 16'h0200);
      chk("midframe_done", done_n - d0, 1);
      chk("midframe_gate_open", 32'(s_data_tready), 1);

      // tlast handshake and drain in the same cycle keep inflight at 1
      send_sample(16'h0a0a, 1'b1);
      filt_out_tlast_hs = 1'b1;
      send_sample(16'h0b0b, 1'b1);
      filt_out_tlast_hs = 1'b0;
      s_coef_tvalid = 1'b1;
      s_coef_tdata  = '0;
      blocked = 0;
      repeat (4) begin
         @(negedge clock);
         if (!s_coef_tready) blocked++;
      end
      chk("drain_hold_wait", blocked, 4);
      filt_out_tlast_hs = 1'b1;
      @(negedge clock);
      filt_out_tlast_hs = 1'b0;
      cnt = 0;
      while (!s_coef_tready && cnt < 5) begin
         @(negedge clock);
         cnt++;
      end
      chk("ready_after_one_drain", 32'(s_coef_tready), 1);
      base = wr_n;
      d0   = done_n;
      send_coef(32, 1'b1, 16'h0300);
      settle();
      check_writes("drain_wr_seq", base, 32, 16'h0300);
      chk("drain_done", done_n - d0, 1);
      m_data_tready = 1'b0;

      // short table
      base = wr_n;
      d0   = done_n;
      e0   = err_n;
      send_coef(10, 1'b1, 16'h0400);
      settle();
      chk("short_wr_count", wr_n - base, 10);
      check_writes("short_wr_seq", base, 10, 16'h0400);
      chk("short_error", err_n - e0, 1);
      chk("short_err_long", 32'(err_long), 0);
      chk("short_valid", 32'(coef_valid), 0);
      chk("short_no_done", done_n - d0, 0);
      chk("short_idle", 32'(busy), 0);
      m_data_tready = 1'b1;
      s_data_tvalid = 1'b1;
      #1;
      chk("short_gate_closed", {m_data_tvalid, s_data_tready}, 0);
      s_data_tvalid = 1'b0;
      m_data_tready = 1'b0;

      // long table
      base = wr_n;
      d0   = done_n;
      e0   = err_n;
      send_coef(40, 1'b1, 16'h0500);
      settle();
      chk("long_wr_count", wr_n - base, 32);
      check_writes("long_wr_seq", base, 32, 16'h0500);
      chk("long_error", err_n - e0, 1);
      chk("long_err_long", 32'(err_long), 1);
      chk("long_valid", 32'(coef_valid), 0);
      chk("long_no_done", done_n - d0, 0);
      chk("long_idle", {busy, s_coef_tready}, 0);

      // reset at load beat 15
      base = wr_n;
      send_coef(15, 1'b0, 16'h0600);
      chk("partial_busy", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("midload_rst_outputs",
          {coeffs_wren, busy, coef_valid, load_done, load_error, err_long,
           s_coef_tready, m_data_tvalid},
          0);
      chk("midload_rst_addr_data", {16'(coeffs_addr), coeffs_wdata}, 0);
      reset = 1'b0;
      chk("partial_wr_count", wr_n - base, 15);
      base = wr_n;
      d0   = done_n;
      send_coef(32, 1'b1, 16'h0700);
      settle();
      check_writes("reload_wr_seq", base, 32, 16'h0700);
      chk("reload_done", done_n - d0, 1);
      chk("reload_valid", 32'(coef_valid), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
